// File: rtl/step_pack_tx.sv
// step_pack_tx: packs one 560-bit CPU step and streams it out LSB byte first.
// Define STEP_PACK_CHECKSUM_EN to append an XOR checksum byte (71-byte frame).
module step_pack_tx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [95:0] raw_instr,
  input  logic [31:0] eax,
  input  logic [31:0] ebx,
  input  logic [31:0] ecx,
  input  logic [31:0] edx,
  input  logic [31:0] esi,
  input  logic [31:0] edi,
  input  logic [31:0] esp,
  input  logic [31:0] ebp,
  input  logic [31:0] eip,
  input  logic [31:0] eflags,
  input  logic [71:0] raw_hint1,
  input  logic [71:0] raw_hint2,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy
);

  typedef enum logic {IDLE, SEND} state_t;

`ifdef STEP_PACK_CHECKSUM_EN
  localparam logic [6:0] LAST = 7'd70;
`else
  localparam logic [6:0] LAST = 7'd69;
`endif

  state_t           state;
  state_t           state_nx;
  logic [69:0][7:0] step_q;
  logic [6:0]       idx;
  logic [7:0]       sel;
  logic             accept;
  logic             hs;

  assign in_ready = (state == IDLE);
  assign busy     = (state == SEND);
  assign tx_valid = busy;
  assign tx_last  = busy && (idx == LAST);
  assign accept   = in_valid && in_ready;
  assign hs       = tx_valid && tx_ready;
  assign tx_data  = sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      step_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        step_q <= {raw_hint2, raw_hint1,
                   eflags, eip, ebp, esp, edi,
                   esi, edx, ecx, ebx, eax,
                   raw_instr};
      end
      if (hs) begin
        idx <= tx_last ? 7'd0 : idx + 7'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = SEND;
      SEND: if (hs && tx_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef STEP_PACK_CHECKSUM_EN
  logic [7:0] csum;

  always_comb begin
    csum = '0;
    for (int k = 0; k < 70; k++) begin
      csum = csum ^ step_q[k];
    end
  end

  always_comb begin
    sel = '0;
    if (busy) begin
      if (idx < 7'd70) sel = step_q[idx];
      else             sel = csum;
    end
  end
`else
  // Output forced to zero when idle so nothing stale leaks onto the link.
  always_comb begin
    sel = '0;
    if (busy) sel = step_q[idx];
  end
`endif

endmodule
